// File: rtl/ti_kbd_matrix_if.sv
// Host-side inputs (PS/2 events, joystick, cursor mode) and the console
// strobe/sense lines of the TI-99/4A keyboard matrix.
interface ti_kbd_matrix_if;
  logic [10:0] ps2_key;
  logic [4:0]  joy;
  logic        cursor_keys;
  logic [7:0]  strobe_n;
  logic [7:0]  sense_n;
  logic        busy;

  modport master (output ps2_key, joy, cursor_keys, strobe_n, input sense_n, busy);
  modport slave  (input ps2_key, joy, cursor_keys, strobe_n, output sense_n, busy);
endinterface

// File: rtl/ti_kbd_matrix.sv
// PS/2 + joystick to TI-99/4A 8x8 keyboard matrix, with a sequencer that
// synthesises FCTN-combination keys so FCTN leads and trails the base key.
module ti_kbd_matrix #(
  parameter logic [15:0] MOD_CYCLES = 16'd2000
) (
  input  logic           clk_sys,
  input  logic           reset,
  ti_kbd_matrix_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRE, HOLD, POST} seq_state_t;
  typedef struct packed {logic valid; logic [2:0] col; logic [2:0] row;} key_pos_t;

  function automatic key_pos_t pos(input logic [2:0] col, input logic [2:0] row);
    pos = '{valid: 1'b1, col: col, row: row};
  endfunction

  // Directly mapped keys; key is {extended, scan code}.
  function automatic key_pos_t plain_decode(input logic [8:0] key);
    plain_decode = '0;
    case (key)
      9'h01C: plain_decode = pos(3'd2, 3'd0); 9'h032: plain_decode = pos(3'd2, 3'd1); // A B
      9'h021: plain_decode = pos(3'd2, 3'd2); 9'h02B: plain_decode = pos(3'd2, 3'd3); // C F
      9'h034: plain_decode = pos(3'd2, 3'd4); 9'h033: plain_decode = pos(3'd2, 3'd5); // G H
      9'h043: plain_decode = pos(3'd2, 3'd6); 9'h03B: plain_decode = pos(3'd2, 3'd7); // I J
      9'h042: plain_decode = pos(3'd3, 3'd0); 9'h04B: plain_decode = pos(3'd3, 3'd1); // K L
      9'h03A: plain_decode = pos(3'd3, 3'd2); 9'h031: plain_decode = pos(3'd3, 3'd3); // M N
      9'h044: plain_decode = pos(3'd3, 3'd4); 9'h04D: plain_decode = pos(3'd3, 3'd5); // O P
      9'h046: plain_decode = pos(3'd3, 3'd6); 9'h015: plain_decode = pos(3'd3, 3'd7); // 9 Q
      9'h058: plain_decode = pos(3'd4, 3'd0); 9'h04C: plain_decode = pos(3'd4, 3'd1); // ALPHA ;
      9'h05A: plain_decode = pos(3'd4, 3'd2); 9'h04A: plain_decode = pos(3'd4, 3'd3); // Enter /
      9'h011: plain_decode = pos(3'd4, 3'd4); 9'h016: plain_decode = pos(3'd4, 3'd5); // FCTN 1
      9'h03D: plain_decode = pos(3'd5, 3'd0); 9'h03E: plain_decode = pos(3'd5, 3'd1); // 7 8
      9'h055: plain_decode = pos(3'd5, 3'd2); 9'h049: plain_decode = pos(3'd5, 3'd3); // = .
      9'h023: plain_decode = pos(3'd5, 3'd4); 9'h01B: plain_decode = pos(3'd5, 3'd5); // D S
      9'h041: plain_decode = pos(3'd5, 3'd6); 9'h012: plain_decode = pos(3'd5, 3'd7); // , LShift
      9'h059: plain_decode = pos(3'd5, 3'd7);                                         // RShift
      9'h02D: plain_decode = pos(3'd6, 3'd0); 9'h02C: plain_decode = pos(3'd6, 3'd1); // R T
      9'h03C: plain_decode = pos(3'd6, 3'd2); 9'h02A: plain_decode = pos(3'd6, 3'd3); // U V
      9'h01D: plain_decode = pos(3'd6, 3'd4); 9'h024: plain_decode = pos(3'd6, 3'd5); // W E
      9'h035: plain_decode = pos(3'd6, 3'd6); 9'h014: plain_decode = pos(3'd6, 3'd7); // Y CTRL
      9'h01A: plain_decode = pos(3'd7, 3'd0); 9'h045: plain_decode = pos(3'd7, 3'd1); // Z 0
      9'h01E: plain_decode = pos(3'd7, 3'd2); 9'h026: plain_decode = pos(3'd7, 3'd3); // 2 3
      9'h025: plain_decode = pos(3'd7, 3'd4); 9'h02E: plain_decode = pos(3'd7, 3'd5); // 4 5
      9'h022: plain_decode = pos(3'd7, 3'd6); 9'h036: plain_decode = pos(3'd7, 3'd7); // X 6
      9'h029: plain_decode = pos(3'd1, 3'd7);                                         // Space
      default: plain_decode = '0;
    endcase
  endfunction

  // Keys that need FCTN; the base key position is returned.
  function automatic key_pos_t comp_decode(input logic [8:0] key, input logic cursor);
    comp_decode = '0;
    case (key)
      9'h066: comp_decode = pos(3'd5, 3'd5);                     // Backspace -> S
      9'h171: comp_decode = pos(3'd4, 3'd5);                     // Delete    -> 1
      9'h076: comp_decode = pos(3'd3, 3'd6);                     // Esc       -> 9
      9'h175: if (cursor) comp_decode = pos(3'd6, 3'd5);         // Up    -> E
      9'h172: if (cursor) comp_decode = pos(3'd7, 3'd6);         // Down  -> X
      9'h16B: if (cursor) comp_decode = pos(3'd5, 3'd5);         // Left  -> S
      9'h174: if (cursor) comp_decode = pos(3'd5, 3'd4);         // Right -> D
      default: comp_decode = '0;
    endcase
  endfunction

  // Arrow keys as joystick directions, same bit order as joy[3:0].
  function automatic logic [3:0] arrow_decode(input logic [8:0] key);
    case (key)
      9'h175:  arrow_decode = 4'b1000;
      9'h172:  arrow_decode = 4'b0100;
      9'h16B:  arrow_decode = 4'b0010;
      9'h174:  arrow_decode = 4'b0001;
      default: arrow_decode = 4'b0000;
    endcase
  endfunction

  logic             toggle_q;
  logic [7:0][7:0]  key_q;      // [column][row]
  logic [3:0]       arrow_q;
  seq_state_t       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  key_pos_t         base_q, base_d;
  logic [8:0]       latch_q, latch_d;
  logic             pend_q, pend_d;
  logic             busy_q;
  logic [7:0]       sense_q;
  logic [7:0][7:0]  mat;
  logic [7:0]       sel;
  logic [4:0]       joy_all;

  logic       ev;
  logic       pressed;
  logic [8:0] key_code;
  key_pos_t   plain, comp;
  logic [3:0] arrow;
  logic       brk;

  assign ev       = bus.ps2_key[10] ^ toggle_q;
  assign pressed  = bus.ps2_key[9];
  assign key_code = bus.ps2_key[8:0];
  assign plain    = plain_decode(key_code);
  assign comp     = comp_decode(key_code, bus.cursor_keys);
  assign arrow    = arrow_decode(key_code);
  assign brk      = ev && !pressed && (key_code == latch_q);
  assign joy_all  = bus.joy | {1'b0, arrow_q};

  // Event edge detect and physical key make/break state.
  always_ff @(posedge clk_sys) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    toggle_q <= bus.ps2_key[10];
    if (reset) begin
      // NOTE: the key array is flops, not RAM, so it can and must be cleared.
      key_q   <= '0;
      arrow_q <= '0;
    end else if (ev) begin
      if (plain.valid) key_q[plain.col][plain.row] <= pressed;
      if (!pressed)                 arrow_q <= arrow_q & ~arrow;
      else if (!bus.cursor_keys)    arrow_q <= arrow_q | arrow;
    end
  end

  // Composite sequencer: next state, counter and latched key.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    latch_d = latch_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: if (ev && pressed && comp.valid) begin
        base_d  = comp;
        latch_d = key_code;
        cnt_d   = MOD_CYCLES - 16'd1;
        pend_d  = 1'b0;
        state_d = PRE;
      end
      PRE: begin
        if (brk) pend_d = 1'b1;
        if (cnt_q == 16'd0) state_d = HOLD;
        else                cnt_d   = cnt_q - 16'd1;
      end
      HOLD: if (brk || pend_q) begin
        cnt_d   = MOD_CYCLES - 16'd1;
        pend_d  = 1'b0;
        state_d = POST;
      end
      POST: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; busy tracks the registered state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      latch_q <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      latch_q <= latch_d;
      pend_q  <= pend_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Full matrix image and the OR of all strobed columns.
  always_comb begin
    mat = key_q;
    for (int c = 0; c < 2; c++) begin
      mat[c][0] = mat[c][0] | joy_all[4];
      mat[c][1] = mat[c][1] | joy_all[1];
      mat[c][2] = mat[c][2] | joy_all[0];
      mat[c][3] = mat[c][3] | joy_all[2];
      mat[c][4] = mat[c][4] | joy_all[3];
    end
    mat[4][0] = mat[4][0] | joy_all[3];
    mat[4][4] = mat[4][4] | (state_q != IDLE);
    if (state_q == HOLD) mat[base_q.col][base_q.row] = 1'b1;
    sel = '0;
    for (int c = 0; c < 8; c++)
      if (!bus.strobe_n[c]) sel = sel | mat[c];
  end

  // Registered active-low sense lines.
  always_ff @(posedge clk_sys) begin
    if (reset) sense_q <= 8'hFF;
    else       sense_q <= ~sel;
  end

  assign bus.sense_n = sense_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_ti_kbd_matrix.sv
// Directed self-checking bench for ti_kbd_matrix (MOD_CYCLES = 4).
module tb_ti_kbd_matrix;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  ti_kbd_matrix_if bus ();

  ti_kbd_matrix #(.MOD_CYCLES(16'd4)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Toggle the event bit with a new key event.
  task automatic send_key(input logic pressed, input logic [8:0] key);
    bus.ps2_key = {~bus.ps2_key[10], pressed, key};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.ps2_key = '0;
    bus.joy = '0;
    bus.cursor_keys = 1'b1;
    bus.strobe_n = 8'hEF;
    tick(3);
    reset = 1'b0;
    tick(2);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL reset_sense got=%h exp=%h", bus.sense_n, 8'hFF); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_plain_key;
    bus.strobe_n = 8'hDF;
    send_key(1'b1, 9'h01B);
    tick(1);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL s_latency got=%h exp=%h", bus.sense_n, 8'hFF); end
    tick(1);
    checks++; if (bus.sense_n !== 8'hDF) begin failures++; $display("FAIL s_press got=%h exp=%h", bus.sense_n, 8'hDF); end
    send_key(1'b1, 9'h012);
    tick(2);
    checks++; if (bus.sense_n !== 8'h5F) begin failures++; $display("FAIL s_shift got=%h exp=%h", bus.sense_n, 8'h5F); end
    send_key(1'b0, 9'h012);
    send_key(1'b0, 9'h012);
    send_key(1'b0, 9'h012);
    tick(2);
    checks++; if (bus.sense_n !== 8'hDF) begin failures++; $display("FAIL shift_release got=%h exp=%h", bus.sense_n, 8'hDF); end
    send_key(1'b1, 9'h05A);
    bus.strobe_n = 8'hCF;
    tick(2);
    checks++; if (bus.sense_n !== 8'hDB) begin failures++; $display("FAIL ghost_two_cols got=%h exp=%h", bus.sense_n, 8'hDB); end
    bus.strobe_n = 8'hEF;
    tick(1);
    checks++; if (bus.sense_n !== 8'hFB) begin failures++; $display("FAIL enter got=%h exp=%h", bus.sense_n, 8'hFB); end
    bus.strobe_n = 8'hFF;
    tick(1);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL no_strobe got=%h exp=%h", bus.sense_n, 8'hFF); end
    send_key(1'b0, 9'h05A);
    tick(1);
    send_key(1'b0, 9'h01B);
    bus.strobe_n = 8'hCF;
    tick(2);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL s_break got=%h exp=%h", bus.sense_n, 8'hFF); end
  endtask

  task automatic test_backspace;
    logic [7:0] exp;
    bus.strobe_n = 8'hEF;
    send_key(1'b1, 9'h066);
    tick(1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL bs_busy_start got=%b exp=1", bus.busy); end
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL bs_latency got=%h exp=%h", bus.sense_n, 8'hFF); end
    for (int i = 0; i < 4; i++) begin
      bus.strobe_n = (i % 2 == 1) ? 8'hDF : 8'hEF;
      exp = (i % 2 == 1) ? 8'hFF : 8'hEF;
      tick(1);
      checks++; if (bus.sense_n !== exp) begin failures++; $display("FAIL bs_pre_%0d got=%h exp=%h", i, bus.sense_n, exp); end
    end
    bus.strobe_n = 8'hDF;
    tick(1);
    checks++; if (bus.sense_n !== 8'hDF) begin failures++; $display("FAIL bs_hold_s got=%h exp=%h", bus.sense_n, 8'hDF); end
    bus.strobe_n = 8'hEF;
    tick(1);
    checks++; if (bus.sense_n !== 8'hEF) begin failures++; $display("FAIL bs_hold_fctn got=%h exp=%h", bus.sense_n, 8'hEF); end
    send_key(1'b0, 9'h066);
    bus.strobe_n = 8'hDF;
    tick(1);
    checks++; if (bus.sense_n !== 8'hDF) begin failures++; $display("FAIL bs_break_edge got=%h exp=%h", bus.sense_n, 8'hDF); end
    tick(1);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL bs_s_clear got=%h exp=%h", bus.sense_n, 8'hFF); end
    bus.strobe_n = 8'hEF;
    for (int i = 2; i <= 4; i++) begin
      tick(1);
      checks++; if (bus.sense_n !== 8'hEF) begin failures++; $display("FAIL bs_post_%0d got=%h exp=%h", i, bus.sense_n, 8'hEF); end
      checks++; if (bus.busy !== (i < 4)) begin failures++; $display("FAIL bs_post_busy_%0d got=%b exp=%b", i, bus.busy, (i < 4)); end
    end
    tick(1);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL bs_fctn_clear got=%h exp=%h", bus.sense_n, 8'hFF); end
  endtask

  task automatic test_joystick;
    bus.cursor_keys = 1'b0;
    bus.joy = 5'b10000;
    bus.strobe_n = 8'hFC;
    tick(1);
    checks++; if (bus.sense_n !== 8'hFE) begin failures++; $display("FAIL joy_fire got=%h exp=%h", bus.sense_n, 8'hFE); end
    bus.joy = 5'b00010;
    bus.strobe_n = 8'hFE;
    tick(1);
    checks++; if (bus.sense_n !== 8'hFD) begin failures++; $display("FAIL joy_left got=%h exp=%h", bus.sense_n, 8'hFD); end
    bus.joy = 5'b01000;
    bus.strobe_n = 8'hEF;
    tick(1);
    checks++; if (bus.sense_n !== 8'hFE) begin failures++; $display("FAIL joy_up_alpha got=%h exp=%h", bus.sense_n, 8'hFE); end
    bus.strobe_n = 8'hFE;
    tick(1);
    checks++; if (bus.sense_n !== 8'hEF) begin failures++; $display("FAIL joy_up got=%h exp=%h", bus.sense_n, 8'hEF); end
    bus.joy = 5'b00000;
    tick(1);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL joy_none got=%h exp=%h", bus.sense_n, 8'hFF); end
    send_key(1'b1, 9'h175);
    tick(2);
    checks++; if (bus.sense_n !== 8'hEF) begin failures++; $display("FAIL arrow_joy_up got=%h exp=%h", bus.sense_n, 8'hEF); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arrow_joy_busy got=%b exp=0", bus.busy); end
    send_key(1'b0, 9'h175);
    tick(2);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL arrow_joy_release got=%h exp=%h", bus.sense_n, 8'hFF); end
  endtask

  task automatic test_esc_delete;
    bus.cursor_keys = 1'b1;
    bus.strobe_n = 8'hF7;
    send_key(1'b1, 9'h076);
    tick(1);
    send_key(1'b1, 9'h171);
    tick(6);
    checks++; if (bus.sense_n !== 8'hBF) begin failures++; $display("FAIL esc_nine got=%h exp=%h", bus.sense_n, 8'hBF); end
    bus.strobe_n = 8'hEF;
    tick(1);
    checks++; if (bus.sense_n !== 8'hEF) begin failures++; $display("FAIL esc_no_one got=%h exp=%h", bus.sense_n, 8'hEF); end
    bus.strobe_n = 8'hE7;
    tick(1);
    checks++; if (bus.sense_n !== 8'hAF) begin failures++; $display("FAIL esc_cols34 got=%h exp=%h", bus.sense_n, 8'hAF); end
    send_key(1'b0, 9'h076);
    tick(7);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL esc_idle_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL esc_released got=%h exp=%h", bus.sense_n, 8'hFF); end
    send_key(1'b0, 9'h171);
    tick(2);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL del_break_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL del_break_sense got=%h exp=%h", bus.sense_n, 8'hFF); end
  endtask

  task automatic test_break_in_pre;
    logic [7:0] exp_s;
    logic       exp_b;
    bus.strobe_n = 8'hDF;
    send_key(1'b1, 9'h066);
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      exp_s = (k == 6) ? 8'hDF : 8'hFF;
      exp_b = (k <= 9);
      checks++; if (bus.sense_n !== exp_s) begin failures++; $display("FAIL pre_break_sense_%0d got=%h exp=%h", k, bus.sense_n, exp_s); end
      checks++; if (bus.busy !== exp_b) begin failures++; $display("FAIL pre_break_busy_%0d got=%b exp=%b", k, bus.busy, exp_b); end
      if (k == 1) send_key(1'b0, 9'h066);
    end
  endtask

  task automatic test_mode_change;
    bus.cursor_keys = 1'b1;
    bus.strobe_n = 8'hBF;
    send_key(1'b1, 9'h175);
    tick(7);
    checks++; if (bus.sense_n !== 8'hDF) begin failures++; $display("FAIL up_hold_e got=%h exp=%h", bus.sense_n, 8'hDF); end
    bus.cursor_keys = 1'b0;
    tick(3);
    checks++; if (bus.sense_n !== 8'hDF) begin failures++; $display("FAIL mode_change_hold got=%h exp=%h", bus.sense_n, 8'hDF); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mode_change_busy got=%b exp=1", bus.busy); end
    send_key(1'b0, 9'h175);
    tick(7);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL up_release_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL up_release_sense got=%h exp=%h", bus.sense_n, 8'hFF); end
    bus.strobe_n = 8'hFE;
    tick(1);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL up_no_joy got=%h exp=%h", bus.sense_n, 8'hFF); end
    send_key(1'b1, 9'h175);
    tick(2);
    checks++; if (bus.sense_n !== 8'hEF) begin failures++; $display("FAIL up_new_mode got=%h exp=%h", bus.sense_n, 8'hEF); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL up_new_mode_busy got=%b exp=0", bus.busy); end
    send_key(1'b0, 9'h175);
    tick(2);
  endtask

  task automatic test_reset_mid_hold;
    bus.cursor_keys = 1'b1;
    bus.strobe_n = 8'hDF;
    send_key(1'b1, 9'h066);
    tick(7);
    checks++; if (bus.sense_n !== 8'hDF) begin failures++; $display("FAIL rst_pre_hold got=%h exp=%h", bus.sense_n, 8'hDF); end
    reset = 1'b1;
    send_key(1'b1, 9'h01B);
    tick(1);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL rst_mid_sense got=%h exp=%h", bus.sense_n, 8'hFF); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    tick(1);
    reset = 1'b0;
    tick(3);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL rst_stale_event got=%h exp=%h", bus.sense_n, 8'hFF); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_after_busy got=%b exp=0", bus.busy); end
    send_key(1'b1, 9'h01B);
    tick(2);
    checks++; if (bus.sense_n !== 8'hDF) begin failures++; $display("FAIL rst_fresh_event got=%h exp=%h", bus.sense_n, 8'hDF); end
    send_key(1'b0, 9'h01B);
    tick(2);
    checks++; if (bus.sense_n !== 8'hFF) begin failures++; $display("FAIL rst_fresh_break got=%h exp=%h", bus.sense_n, 8'hFF); end
  endtask

  initial begin
    test_reset;
    test_plain_key;
    test_backspace;
    test_joystick;
    test_esc_delete;
    test_break_in_pre;
    test_mode_change;
    test_reset_mid_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
